// File: rtl/decoder4_seq_ctrl.sv
// decoder4_seq_ctrl: clears, programs and streams host words into one decoder4, counting tagged matches.
// Optional DEC_FIRST_MATCH_EN adds first_pos, the data-bit index of the first counted match.
`default_nettype none

module decoder4_seq_ctrl #(
   parameter int DATA_W  = 16,
   parameter int CNT_W   = 8,
   parameter int DEC_LAT = 1
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              start,
   input  logic [3:0]        pattern,
   input  logic              word_valid,
   output logic              word_ready,
   input  logic [DATA_W-1:0] word_data,
   input  logic              word_last,
   output logic              dec_clr,
   output logic              dec_prgm,
   output logic              dec_sig,
   input  logic              dec_out,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  match_count
`ifdef DEC_FIRST_MATCH_EN
   ,
   output logic [15:0]       first_pos
`endif
);

   localparam int BCNT_W = $clog2(DATA_W + 1);
   localparam int DCNT_W = (DEC_LAT > 1) ? $clog2(DEC_LAT) : 1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CLEAR  = 3'd1,
      S_PROG   = 3'd2,
      S_STREAM = 3'd3,
      S_DRAIN  = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic [3:0]          pat_q, pat_d;
   logic [1:0]          pcnt_q, pcnt_d;
   logic [DATA_W-1:0]   sh_q, sh_d;
   logic [BCNT_W-1:0]   rem_q, rem_d;
   logic                vcur_q, vcur_d;
   logic                last_q, last_d;
   logic [DEC_LAT-1:0]  dly_q, dly_d;
   logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                clr_q, clr_d;
   logic                prgm_q, prgm_d;
   logic                sig_q, sig_d;
   logic                ready_q, ready_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic                start_acc;
   logic                word_acc;
   logic                hit;

   assign start_acc = (state_q == S_IDLE) && start;
   assign word_acc  = word_valid && ready_q;
   // dly_q tail holds the valid tag of the bit that dec_out currently reflects
   assign hit       = dec_out && dly_q[DEC_LAT-1];

   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      pcnt_d  = pcnt_q;
      sh_d    = sh_q;
      rem_d   = rem_q;
      vcur_d  = 1'b0;
      last_d  = last_q;
      dcnt_d  = dcnt_q;
      prgm_d  = 1'b0;
      sig_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_CLEAR;
               pat_d   = pattern;
               last_d  = 1'b0;
            end
         end
         S_CLEAR: begin
            state_d = S_PROG;
            pcnt_d  = 2'd0;
            prgm_d  = pat_q[3];
         end
         S_PROG: begin
            if (pcnt_q == 2'd3) begin
               state_d = S_STREAM;
               rem_d   = '0;
            end else begin
               pcnt_d = pcnt_q + 2'd1;
               case (pcnt_q)
                  2'd0:    prgm_d = pat_q[2];
                  2'd1:    prgm_d = pat_q[1];
                  default: prgm_d = pat_q[0];
               endcase
            end
         end
         S_STREAM: begin
            if (word_acc) begin
               sig_d  = word_data[DATA_W-1];
               sh_d   = word_data << 1;
               rem_d  = BCNT_W'(DATA_W - 1);
               vcur_d = 1'b1;
               last_d = word_last;
            end else if (vcur_q && (rem_q != '0)) begin
               sig_d  = sh_q[DATA_W-1];
               sh_d   = sh_q << 1;
               rem_d  = rem_q - BCNT_W'(1);
               vcur_d = 1'b1;
            end else if (vcur_q && last_q) begin
               state_d = S_DRAIN;
               dcnt_d  = '0;
            end
         end
         S_DRAIN: begin
            if (dcnt_q == DCNT_W'(DEC_LAT - 1)) begin
               state_d = S_DONE;
            end else begin
               dcnt_d = dcnt_q + DCNT_W'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Ready during the final bit of a word gives back-to-back words no bubble
      ready_d = (state_d == S_STREAM) && !last_d && (!vcur_d || (rem_d == '0));
      busy_d  = (state_d != S_IDLE);
      done_d  = (state_d == S_DONE);
      clr_d   = (state_d == S_CLEAR);
   end

   always_comb begin
      dly_d[0] = vcur_q;
      for (int i = 1; i < DEC_LAT; i++) begin
         dly_d[i] = dly_q[i-1];
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (start_acc) begin
         cnt_d = '0;
      end else if (hit && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q <= S_IDLE;
         pat_q   <= '0;
         pcnt_q  <= '0;
         sh_q    <= '0;
         rem_q   <= '0;
         vcur_q  <= 1'b0;
         last_q  <= 1'b0;
         dly_q   <= '0;
         dcnt_q  <= '0;
         cnt_q   <= '0;
         clr_q   <= 1'b1;
         prgm_q  <= 1'b0;
         sig_q   <= 1'b0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         pcnt_q  <= pcnt_d;
         sh_q    <= sh_d;
         rem_q   <= rem_d;
         vcur_q  <= vcur_d;
         last_q  <= last_d;
         dly_q   <= dly_d;
         dcnt_q  <= dcnt_d;
         cnt_q   <= cnt_d;
         clr_q   <= clr_d;
         prgm_q  <= prgm_d;
         sig_q   <= sig_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign word_ready  = ready_q;
   assign dec_clr     = clr_q;
   assign dec_prgm    = prgm_q;
   assign dec_sig     = sig_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign match_count = cnt_q;

`ifdef DEC_FIRST_MATCH_EN
   logic [15:0] idx_q, idx_d;
   logic [15:0] fpos_q, fpos_d;

   // idx_q counts tagged bits as they reach the tap, so it is the index of the tapped bit
   always_comb begin
      idx_d  = idx_q;
      fpos_d = fpos_q;
      if (start_acc) begin
         idx_d  = '0;
         fpos_d = 16'hFFFF;
      end else if (dly_q[DEC_LAT-1]) begin
         idx_d = idx_q + 16'd1;
         if (dec_out && (fpos_q == 16'hFFFF)) begin
            fpos_d = idx_q;
         end
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         idx_q  <= '0;
         fpos_q <= 16'hFFFF;
      end else begin
         idx_q  <= idx_d;
         fpos_q <= fpos_d;
      end
   end

   assign first_pos = fpos_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_decoder4_seq_ctrl.sv
// Bench for decoder4_seq_ctrl: behavioural decoder4 model, job table, bit-level dec_sig scoreboard.
`default_nettype none

module tb_decoder4_seq_ctrl;

   localparam int DATA_W = 16;

   logic              clk = 1'b0;
   logic              clr = 1'b0;
   logic              start = 1'b0;
   logic [3:0]        pattern = 4'd0;
   logic              word_valid = 1'b0;
   logic [DATA_W-1:0] word_data = '0;
   logic              word_last = 1'b0;
   logic              dec_out;
   logic              word_ready, dec_clr, dec_prgm, dec_sig, busy, done;
   logic [7:0]        match_count;
   logic              s_ready, s_clr, s_prgm, s_sig, s_busy, s_done;
   logic [3:0]        s_cnt;
`ifdef DEC_FIRST_MATCH_EN
   logic [15:0]       first_pos, s_first_pos;
`endif

   always #5 clk = ~clk;

   decoder4_seq_ctrl #(.DATA_W(DATA_W), .CNT_W(8), .DEC_LAT(1)) dut (
      .clk(clk), .clr(clr), .start(start), .pattern(pattern),
      .word_valid(word_valid), .word_ready(word_ready), .word_data(word_data),
      .word_last(word_last), .dec_clr(dec_clr), .dec_prgm(dec_prgm),
      .dec_sig(dec_sig), .dec_out(dec_out), .busy(busy), .done(done),
      .match_count(match_count)
`ifdef DEC_FIRST_MATCH_EN
      , .first_pos(first_pos)
`endif
   );

   // Narrow-counter twin sees identical stimulus and decoder response
   decoder4_seq_ctrl #(.DATA_W(DATA_W), .CNT_W(4), .DEC_LAT(1)) dut_small (
      .clk(clk), .clr(clr), .start(start), .pattern(pattern),
      .word_valid(word_valid), .word_ready(s_ready), .word_data(word_data),
      .word_last(word_last), .dec_clr(s_clr), .dec_prgm(s_prgm),
      .dec_sig(s_sig), .dec_out(dec_out), .busy(s_busy), .done(s_done),
      .match_count(s_cnt)
`ifdef DEC_FIRST_MATCH_EN
      , .first_pos(s_first_pos)
`endif
   );

   // decoder4 model: first 4 bits after clear program the pattern, then sig shifts into history
   logic [3:0] m_pat = 4'd0;
   logic [3:0] m_hist = 4'd0;
   logic [2:0] m_pcnt = 3'd0;
   always @(posedge clk) begin
      if (!clr || dec_clr) begin
         m_pat  <= 4'd0;
         m_hist <= 4'd0;
         m_pcnt <= 3'd0;
      end else if (m_pcnt < 3'd4) begin
         m_pat  <= {m_pat[2:0], dec_prgm};
         m_pcnt <= m_pcnt + 3'd1;
      end else begin
         m_hist <= {m_hist[2:0], dec_sig};
      end
   end
   assign dec_out = (m_pcnt == 3'd4) && (m_hist == m_pat);

   typedef struct {
      logic [3:0]  pat;
      int          nw;
      logic [15:0] w0;
      logic [15:0] w1;
      int          gap;
      bit          inj;
      int          exp_cnt;
      int          exp_small;
      logic [15:0] exp_first;
   } job_t;

   job_t V[6];
   int   checks = 0;
   int   fails = 0;
   int   clr_cyc, done_cnt;
   logic sbq[$];
   logic rdy_s, acc_s, done_s;
   logic [7:0]  cnt_s;
   logic [3:0]  scnt_s;
   logic [15:0] fpos_s;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic mon();
      logic e;
      rdy_s  = word_ready;
      acc_s  = word_valid & word_ready;
      done_s = done;
      cnt_s  = match_count;
      scnt_s = s_cnt;
`ifdef DEC_FIRST_MATCH_EN
      fpos_s = first_pos;
`else
      fpos_s = 16'hFFFF;
`endif
      if (!clr) begin
         sbq.delete();
         return;
      end
      if (busy && dec_clr) clr_cyc++;
      if (done) done_cnt++;
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         chk("dec_sig_data", 32'(dec_sig), 32'(e));
      end else if (busy) begin
         chk("dec_sig_gap", 32'(dec_sig), 32'd0);
      end
      if (word_valid && word_ready) begin
         for (int i = DATA_W - 1; i >= 0; i--) sbq.push_back(word_data[i]);
      end
   endtask

   task automatic step();
      @(negedge clk);
      mon();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_accept();
      int n = 0;
      do begin step(); n++; end while (!acc_s && n < 100);
      chk("word_accept", 32'(acc_s), 32'd1);
   endtask

   task automatic run_job(input int j);
      int n;
      clr_cyc  = 0;
      done_cnt = 0;
      pattern = V[j].pat;
      start   = 1'b1;
      step();
      start   = 1'b0;
      pattern = 4'd0;
      if (V[j].inj) begin
         step();
         start   = 1'b1;
         pattern = 4'hF;
         step();
         start   = 1'b0;
         pattern = 4'd0;
      end
      for (int w = 0; w < V[j].nw; w++) begin
         if (w > 0 && V[j].gap > 0) begin
            word_valid = 1'b0;
            word_last  = 1'b0;
            n = 0;
            do begin step(); n++; end while (!rdy_s && n < 100);
            chk("ready_return", 32'(rdy_s), 32'd1);
            repeat (V[j].gap - 1) step();
         end
         word_valid = 1'b1;
         word_data  = (w == 0) ? V[j].w0 : V[j].w1;
         word_last  = (w == V[j].nw - 1);
         wait_accept();
      end
      word_valid = 1'b0;
      word_last  = 1'b0;
      n = 0;
      do begin step(); n++; end while (!done_s && n < 200);
      chk("done_seen", 32'(done_s), 32'd1);
      chk("match_count", 32'(cnt_s), 32'(V[j].exp_cnt));
      chk("match_count_cnt4", 32'(scnt_s), 32'(V[j].exp_small));
`ifdef DEC_FIRST_MATCH_EN
      chk("first_pos", 32'(fpos_s), 32'(V[j].exp_first));
`endif
      chk("dec_clr_cycles", 32'(clr_cyc), 32'd1);
      chk("programmed_pattern", 32'(m_pat), 32'(V[j].pat));
      repeat (3) step();
      chk("done_pulses", 32'(done_cnt), 32'd1);
      chk("busy_after", 32'(busy), 32'd0);
      chk("count_hold", 32'(match_count), 32'(V[j].exp_cnt));
      chk("count_hold_cnt4", 32'(s_cnt), 32'(V[j].exp_small));
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_dec_clr"}, 32'(dec_clr), 32'd1);
      chk({tag, "_dec_prgm"}, 32'(dec_prgm), 32'd0);
      chk({tag, "_dec_sig"}, 32'(dec_sig), 32'd0);
      chk({tag, "_word_ready"}, 32'(word_ready), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_match_count"}, 32'(match_count), 32'd0);
      chk({tag, "_match_count_cnt4"}, 32'(s_cnt), 32'd0);
`ifdef DEC_FIRST_MATCH_EN
      chk({tag, "_first_pos"}, 32'(first_pos), 32'hFFFF);
`endif
   endtask

   initial begin
      V[0] = '{pat:4'b1010, nw:1, w0:16'b1010000101000000, w1:16'h0000, gap:0, inj:1'b0,
               exp_cnt:2, exp_small:2, exp_first:16'd3};
      V[1] = '{pat:4'b1010, nw:2, w0:16'hAAAA, w1:16'hAAAA, gap:0, inj:1'b0,
               exp_cnt:15, exp_small:15, exp_first:16'd3};
      V[2] = '{pat:4'b0000, nw:2, w0:16'h0000, w1:16'h0000, gap:0, inj:1'b0,
               exp_cnt:32, exp_small:15, exp_first:16'd0};
      V[3] = '{pat:4'b0000, nw:2, w0:16'hFFFF, w1:16'hFFFF, gap:6, inj:1'b0,
               exp_cnt:0, exp_small:0, exp_first:16'hFFFF};
      V[4] = '{pat:4'b1010, nw:1, w0:16'b1010000101000000, w1:16'h0000, gap:0, inj:1'b1,
               exp_cnt:2, exp_small:2, exp_first:16'd3};
      V[5] = '{pat:4'b0110, nw:1, w0:16'h6666, w1:16'h0000, gap:0, inj:1'b0,
               exp_cnt:4, exp_small:4, exp_first:16'd3};

      repeat (2) @(posedge clk);
      #1;
      check_reset_values("reset");
      clr = 1'b1;
      step();
      step();

      for (int j = 0; j < 6; j++) run_job(j);

      // Reset asserted in the 5th STREAM cycle of a job
      pattern = 4'b1010;
      start   = 1'b1;
      step();
      start      = 1'b0;
      pattern    = 4'd0;
      word_valid = 1'b1;
      word_data  = V[0].w0;
      word_last  = 1'b1;
      wait_accept();
      repeat (3) step();
      chk("midjob_busy_before", 32'(busy), 32'd1);
      clr = 1'b0;
      #1;
      check_reset_values("midjob");
      word_valid = 1'b0;
      word_last  = 1'b0;
      step();
      step();
      clr = 1'b1;
      step();
      run_job(0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule

`default_nettype wire
